// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: serialises packet bytes into NRZI-encoded, bit-stuffed USB line states with SYNC and EOP framing.
module usb_tx_encoder #(
  parameter int BIT_CLKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);
  localparam int CW = BIT_CLKS > 1 ? $clog2(BIT_CLKS) : 1;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bidx, bidx_n, ones, ones_n, nb;
  logic [7:0] data, data_n;
  logic [1:0] line, line_n;
  logic last, last_n, end_bit, bnd, eop, drive, bit_v;
  assign {d_plus, d_minus} = line;
  assign tx_active = state != IDLE;
  assign tx_ready = bnd;
  assign tx_err = bnd && !tx_valid;
  assign tx_done = state == EOP_J && end_bit;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bidx  <= '0;
      ones  <= '0;
      data  <= '0;
      last  <= 1'b0;
      line  <= 2'b10;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bidx  <= bidx_n;
      ones  <= ones_n;
      data  <= data_n;
      last  <= last_n;
      line  <= line_n;
    end
  // bidx doubles as the SE0 period counter during EOP_SE0
  always_comb begin
    end_bit = cnt == CW'(BIT_CLKS - 1);
    nb = bidx + 3'd1;
    state_n = state;
    cnt_n = end_bit ? '0 : cnt + 1'b1;
    bidx_n = bidx;
    ones_n = ones;
    data_n = data;
    last_n = last;
    line_n = line;
    bnd = 1'b0;
    eop = 1'b0;
    drive = 1'b0;
    bit_v = 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (tx_valid) begin
          state_n = SYNC;
          bidx_n = '0;
          drive = 1'b1;
          bit_v = 1'b0;
        end
      end
      SYNC: if (end_bit) begin
        if (bidx == 3'd7) bnd = 1'b1;
        else begin
          bidx_n = nb;
          drive = 1'b1;
          bit_v = nb == 3'd7;
        end
      end
      DATA: if (end_bit) begin
        if (ones == 3'd6) begin
          state_n = STUFF;
          drive = 1'b1;
          bit_v = 1'b0;
        end else if (bidx == 3'd7) begin
          bnd = !last;
          eop = last;
        end else begin
          bidx_n = nb;
          drive = 1'b1;
          bit_v = data[nb];
        end
      end
      STUFF: if (end_bit) begin
        if (bidx == 3'd7) begin
          bnd = !last;
          eop = last;
        end else begin
          state_n = DATA;
          bidx_n = nb;
          drive = 1'b1;
          bit_v = data[nb];
        end
      end
      EOP_SE0: if (end_bit) begin
        bidx_n = nb;
        if (bidx[0]) begin
          state_n = EOP_J;
          line_n = 2'b10;
        end
      end
      EOP_J: if (end_bit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bnd) begin
      if (tx_valid) begin
        state_n = DATA;
        bidx_n = '0;
        data_n = tx_data;
        last_n = tx_last;
        drive = 1'b1;
        bit_v = tx_data[0];
      end else eop = 1'b1;
    end
    if (eop) begin
      state_n = EOP_SE0;
      bidx_n = '0;
      line_n = 2'b00;
    end
    if (drive) begin
      ones_n = bit_v ? ones + 3'd1 : 3'd0;
      line_n = bit_v ? line : ~line;
    end
  end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: scoreboard bench; a bit-list model predicts every line symbol, packet length and status pulse.
module tb_usb_tx_encoder;
  localparam int B = 8;
  logic clk = 1'b0;
  logic rst, tx_valid, tx_last, tx_ready, d_plus, d_minus, tx_active, tx_done, tx_err;
  logic [7:0] tx_data;
  always #5 clk = ~clk;
  usb_tx_encoder #(.BIT_CLKS(B)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .d_plus(d_plus), .d_minus(d_minus), .tx_active(tx_active),
    .tx_done(tx_done), .tx_err(tx_err)
  );
  int total = 0, bad = 0;
  logic [7:0] pa[8], pb[8];
  int pb_n;
  logic [1:0] sym_q[$];
  int len_q[$];
  bit err_q[$], gap_q[$];
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // line symbols: J=2'b10, K=2'b01, SE0=2'b00; u>=0 means byte u is withheld
  task automatic expect_pkt(int n, int u, bit gap);
    bit raw[$];
    bit b;
    logic [1:0] lv = 2'b10;
    int ones = 0, nbits = 0;
    int k = u < 0 ? n : u;
    for (int i = 0; i < 8; i++) raw.push_back(i == 7);
    for (int j = 0; j < k; j++) for (int i = 0; i < 8; i++) raw.push_back(pa[j][i]);
    foreach (raw[i]) begin
      b = raw[i];
      if (!b) lv = ~lv;
      sym_q.push_back(lv);
      nbits++;
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        lv = ~lv;
        sym_q.push_back(lv);
        nbits++;
        ones = 0;
      end
    end
    sym_q.push_back(2'b00);
    sym_q.push_back(2'b00);
    sym_q.push_back(2'b10);
    len_q.push_back(nbits + 3);
    err_q.push_back(u >= 0);
    gap_q.push_back(gap);
  endtask
  task automatic wait_ready();
    int t = 0;
    do begin @(negedge clk); t++; end while (!tx_ready && t < 3000);
    if (!tx_ready) chk("ready_wait", tx_ready, 1);
  endtask
  task automatic wait_active();
    int t = 0;
    do begin @(negedge clk); t++; end while (!tx_active && t < 3000);
    if (!tx_active) chk("active_wait", tx_active, 1);
  endtask
  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while (tx_active && t < 3000);
    if (tx_active) chk("end_wait", tx_active, 0);
  endtask
  task automatic send(int n, int u, bit hold);
    int k = u < 0 ? n : u;
    if (!tx_valid) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data = pa[0];
      tx_last = n == 1;
    end
    if (k == 0) begin
      wait_active();
      tx_valid = 1'b0;
    end
    for (int i = 0; i < k; i++) begin
      wait_ready();
      @(negedge clk);
      if (i + 1 < k) begin
        tx_data = pa[i+1];
        tx_last = i + 1 == n - 1;
      end else if (u < 0 && hold) begin
        tx_data = pb[0];
        tx_last = pb_n == 1;
      end else tx_valid = 1'b0;
    end
    if (!(u < 0 && hold)) wait_idle();
  endtask
  int cyc = 0, clks, dones, errs, plen, popped, done_cyc = -100;
  bit perr, pgap, inpkt = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (rst || !tx_active) begin
      chk("idle_outputs", {tx_ready, tx_done, tx_err, d_plus, d_minus}, 5'b00010);
      if (inpkt) begin
        if (rst) begin
          chk("abort_done", dones, 0);
          for (int i = popped; i < plen; i++) void'(sym_q.pop_front());
        end else begin
          chk("pkt_clocks", clks, plen * B);
          chk("pkt_done", dones, 1);
          chk("pkt_err", errs, perr);
        end
        inpkt = 1'b0;
      end
    end else begin
      if (!inpkt) begin
        if (len_q.size() == 0) chk("unexpected_pkt", len_q.size(), 1);
        else begin
          plen = len_q.pop_front();
          perr = err_q.pop_front();
          pgap = gap_q.pop_front();
          if (pgap) chk("restart_gap", cyc - done_cyc, 2);
        end
        inpkt = 1'b1;
        clks = 0;
        dones = 0;
        errs = 0;
        popped = 0;
      end
      chk("line", {d_plus, d_minus}, sym_q.size() > 0 ? sym_q[0] : 2'b11);
      if (tx_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (tx_err) errs++;
      clks++;
      if (clks % B == 0 && popped < plen) begin
        void'(sym_q.pop_front());
        popped++;
      end
    end
  end
  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = '0;
    tx_last = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    pa[0] = 8'hD2; expect_pkt(1, -1, 0); send(1, -1, 0);
    pa[0] = 8'hFF; expect_pkt(1, -1, 0); send(1, -1, 0);
    pa[0] = 8'hC3; pa[1] = 8'hA5; expect_pkt(2, 1, 0); send(2, 1, 0);
    pa[0] = 8'hD2; expect_pkt(1, -1, 0);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'hD2;
    tx_last = 1'b1;
    wait_active();
    repeat (11 * B + 2) @(negedge clk);
    #2 rst = 1'b1;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    pa[0] = 8'hD2; expect_pkt(1, -1, 0); send(1, -1, 0);
    pa[0] = 8'hD2; pb[0] = 8'hFF; pb_n = 1;
    expect_pkt(1, -1, 0); send(1, -1, 1);
    pa[0] = pb[0]; expect_pkt(1, -1, 1); send(1, -1, 0);
    for (int it = 0; it < 16; it++) begin
      int n, u;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) pa[j] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        pb_n = $urandom_range(1, 4);
        for (int j = 0; j < pb_n; j++) pb[j] = 8'($urandom);
        expect_pkt(n, -1, 0);
        send(n, -1, 1);
        for (int j = 0; j < pb_n; j++) pa[j] = pb[j];
        expect_pkt(pb_n, -1, 1);
        send(pb_n, -1, 0);
      end else begin
        u = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, n - 1)) : -1;
        expect_pkt(n, u, 0);
        send(n, u, 0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("queue_drained", len_q.size() + sym_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
